// File: rtl/cva6_mem_arb_pkg.sv
// Shared types and constants for the CVA6 memory request arbiter.
// Requester order: icache miss, dcache load miss, write-through buffer.
package cva6_mem_arb_pkg;

    localparam int unsigned ARB_NUM_REQ    = 3;
    localparam int unsigned ARB_ADDR_W     = 64;
    localparam int unsigned ARB_DATA_W     = 64;
    localparam int unsigned ARB_TID_W      = 3;
    localparam int unsigned ARB_MAX_STORES = 7;
    localparam int unsigned ARB_REQ_W      = $clog2(ARB_NUM_REQ);

    localparam int unsigned REQ_ICACHE = 0;
    localparam int unsigned REQ_DCACHE = 1;
    localparam int unsigned REQ_WBUF   = 2;

    typedef struct packed {
        logic                    we;
        logic [ARB_ADDR_W-1:0]   addr;
        logic [ARB_DATA_W-1:0]   wdata;
        logic [ARB_DATA_W/8-1:0] be;
    } mem_req_t;

    typedef struct packed {
        logic                 in_use;
        logic [ARB_REQ_W-1:0] owner;
        logic                 is_store;
    } tid_entry_t;

endpackage

// File: rtl/cva6_mem_arb_rr.sv
// Round-robin picker: one-hot grant from an eligibility mask.
// The pointer moves to one past the winner on every grant.
module cva6_mem_arb_rr #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic [N-1:0]  mask_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    // search from the pointer, first eligible requester wins
    always_comb begin
        int unsigned cand;
        logic        found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        if (en_i) begin
            for (int unsigned k = 0; k < N; k++) begin
                cand = (32'(ptr_q) + k) % N;
                if (!found && mask_i[cand]) begin
                    found        = 1'b1;
                    gnt_o[cand]  = 1'b1;
                    idx_o        = IW'(cand);
                end
            end
        end
    end

    // advance the pointer past the granted requester
    always_comb begin
        ptr_d = ptr_q;
        if (|gnt_o) begin
            ptr_d = (idx_o == IW'(N-1)) ? '0 : idx_o + IW'(1);
        end
    end

    // pointer register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/cva6_mem_req_arbiter.sv
// Shares the CVA6 memory request port: RR grant, TID pool, store throttle.
// Optional MEM_ARB_PERF_CNT_EN adds stall and store-throttle counters.
module cva6_mem_req_arbiter
    import cva6_mem_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = ARB_NUM_REQ,
    parameter int unsigned DATA_W         = ARB_DATA_W,
    parameter int unsigned TID_W          = ARB_TID_W,
    parameter int unsigned MAX_OUT_STORES = ARB_MAX_STORES
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  mem_req_t [NUM_REQ-1:0]    req_i,
    output logic                      mem_valid_o,
    input  logic                      mem_ready_i,
    output mem_req_t                  mem_req_o,
    output logic [TID_W-1:0]          mem_tid_o,
    input  logic                      mem_rsp_valid_i,
    input  logic [TID_W-1:0]          mem_rsp_tid_i,
    input  logic [DATA_W-1:0]         mem_rsp_data_i,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [DATA_W-1:0]         rsp_data_o,
    output logic                      busy_o
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]               stall_cnt_o,
    output logic [31:0]               store_throttle_cnt_o
`endif
);

    localparam int unsigned NUM_TID = 2**TID_W;
    localparam int unsigned CNT_W   = $clog2(MAX_OUT_STORES + 1);
    localparam int unsigned REQ_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    tid_entry_t [NUM_TID-1:0] tbl_q, tbl_d;
    logic [CNT_W-1:0]         st_cnt_q, st_cnt_d;
    logic                     mem_valid_q, mem_valid_d;
    mem_req_t                 mem_req_q, mem_req_d;
    logic [TID_W-1:0]         mem_tid_q, mem_tid_d;

    logic                     free_any;
    logic [TID_W-1:0]         free_idx;
    logic                     any_busy;
    logic                     st_full;
    logic                     can_issue;
    logic [NUM_REQ-1:0]       we_vec;
    logic [NUM_REQ-1:0]       elig;
    logic [NUM_REQ-1:0]       gnt;
    logic [REQ_W-1:0]         gnt_idx;
    tid_entry_t               rsp_entry;
    logic                     rsp_hit;

    // lowest free TID from the registered table; freed entries wait a cycle
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        any_busy = 1'b0;
        for (int i = NUM_TID-1; i >= 0; i--) begin
            if (!tbl_q[i].in_use) begin
                free_any = 1'b1;
                free_idx = TID_W'(i);
            end else begin
                any_busy = 1'b1;
            end
        end
    end

    // stores are masked at the limit; loads only need a free TID
    always_comb begin
        st_full   = (st_cnt_q == CNT_W'(MAX_OUT_STORES));
        can_issue = ~mem_valid_q | mem_ready_i;
        for (int i = 0; i < NUM_REQ; i++) begin
            we_vec[i] = req_i[i].we;
            elig[i]   = req_valid_i[i] & free_any & ~(req_i[i].we & st_full);
        end
    end

    cva6_mem_arb_rr #(
        .N  (NUM_REQ),
        .IW (REQ_W)
    ) i_rr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (can_issue),
        .mask_i (elig),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx)
    );

    // route responses to the TID owner; unknown TIDs are dropped
    always_comb begin
        rsp_entry = tbl_q[mem_rsp_tid_i];
        rsp_hit   = mem_rsp_valid_i & rsp_entry.in_use;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid_o[i] = rsp_hit & (rsp_entry.owner == REQ_W'(i));
        end
        rsp_data_o = rsp_hit ? mem_rsp_data_i : '0;
    end

    // free on response, allocate on grant; the two never hit the same TID
    always_comb begin
        tbl_d    = tbl_q;
        st_cnt_d = st_cnt_q;
        if (rsp_hit) begin
            tbl_d[mem_rsp_tid_i] = '0;
            if (rsp_entry.is_store) begin
                st_cnt_d = st_cnt_d - CNT_W'(1);
            end
        end
        if (|gnt) begin
            tbl_d[free_idx].in_use   = 1'b1;
            tbl_d[free_idx].owner    = gnt_idx;
            tbl_d[free_idx].is_store = req_i[gnt_idx].we;
            if (req_i[gnt_idx].we) begin
                st_cnt_d = st_cnt_d + CNT_W'(1);
            end
        end
    end

    // output register holds the payload until memory takes it
    always_comb begin
        mem_valid_d = mem_valid_q;
        mem_req_d   = mem_req_q;
        mem_tid_d   = mem_tid_q;
        if (|gnt) begin
            mem_valid_d = 1'b1;
            mem_req_d   = req_i[gnt_idx];
            mem_tid_d   = free_idx;
        end else if (mem_ready_i) begin
            mem_valid_d = 1'b0;
        end
    end

    // state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tbl_q       <= '0;
            st_cnt_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_req_q   <= '0;
            mem_tid_q   <= '0;
        end else begin
            tbl_q       <= tbl_d;
            st_cnt_q    <= st_cnt_d;
            mem_valid_q <= mem_valid_d;
            mem_req_q   <= mem_req_d;
            mem_tid_q   <= mem_tid_d;
        end
    end

    assign req_ready_o = gnt;
    assign mem_valid_o = mem_valid_q;
    assign mem_req_o   = mem_req_q;
    assign mem_tid_o   = mem_tid_q;
    assign busy_o      = any_busy | mem_valid_q;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] thr_cnt_q, thr_cnt_d;

    // saturating stall and throttle counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        thr_cnt_d   = thr_cnt_q;
        if ((|req_valid_i) && !(|gnt) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if ((|(req_valid_i & we_vec)) && st_full && (thr_cnt_q != '1)) begin
            thr_cnt_d = thr_cnt_q + 32'd1;
        end
    end

    // counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            thr_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            thr_cnt_q   <= thr_cnt_d;
        end
    end

    assign stall_cnt_o          = stall_cnt_q;
    assign store_throttle_cnt_o = thr_cnt_q;
`endif

`ifndef SYNTHESIS
    a_rsp_tid_in_use: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        mem_rsp_valid_i |-> tbl_q[mem_rsp_tid_i].in_use
    ) else $warning("response to free tid %0d dropped", mem_rsp_tid_i);
`endif

endmodule

// File: tb/tb_cva6_mem_req_arbiter.sv
// Randomized bench for cva6_mem_req_arbiter against a transaction-level model.
// Model tracks the TID pool, store count, RR pointer and output slot.
module tb_cva6_mem_req_arbiter;
    import cva6_mem_arb_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      rv;
    mem_req_t [2:0]  rq;
    logic            mem_ready;
    logic            rsp_v;
    logic [2:0]      rsp_tid;
    logic [63:0]     rsp_data;
    logic [2:0]      req_ready;
    logic            mem_valid;
    mem_req_t        mreq;
    logic [2:0]      mtid;
    logic [2:0]      rsp_valid;
    logic [63:0]     rdata;
    logic            busy;

    always #5 clk = ~clk;

    cva6_mem_req_arbiter dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (rv),
        .req_ready_o     (req_ready),
        .req_i           (rq),
        .mem_valid_o     (mem_valid),
        .mem_ready_i     (mem_ready),
        .mem_req_o       (mreq),
        .mem_tid_o       (mtid),
        .mem_rsp_valid_i (rsp_v),
        .mem_rsp_tid_i   (rsp_tid),
        .mem_rsp_data_i  (rsp_data),
        .rsp_valid_o     (rsp_valid),
        .rsp_data_o      (rdata),
        .busy_o          (busy)
    );

    int nrun = 0;
    int nfail = 0;

    bit       m_busy [8];
    int       m_owner [8];
    bit       m_st [8];
    int       m_stores;
    int       m_ptr;
    bit       m_ov;
    int       m_otid;
    mem_req_t m_oreq;

    logic [2:0]  s_ready, s_rsp, e_ready, e_rsp;
    logic [63:0] s_data;

    function automatic void model_reset();
        for (int t = 0; t < 8; t++) begin
            m_busy[t] = 0; m_owner[t] = 0; m_st[t] = 0;
        end
        m_stores = 0; m_ptr = 0; m_ov = 0; m_otid = 0; m_oreq = '0;
    endfunction

    function automatic bit model_any_busy();
        bit b = 0;
        for (int t = 0; t < 8; t++) if (m_busy[t]) b = 1;
        return b;
    endfunction

    task automatic set_req(input int i, input bit we);
        rq[i].we    = we;
        rq[i].addr  = {$urandom, $urandom};
        rq[i].wdata = {$urandom, $urandom};
        rq[i].be    = 8'($urandom);
    endtask

    task automatic idle();
        rv = 3'b000; rsp_v = 1'b0; rsp_tid = '0;
        rsp_data = {$urandom, $urandom}; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) set_req(i, 0);
    endtask

    // one clock: sample combinational outputs, predict, advance model
    task automatic tick();
        int ft, g, cand;
        #1;
        s_ready = req_ready; s_rsp = rsp_valid; s_data = rdata;
        ft = -1;
        for (int t = 7; t >= 0; t--) if (!m_busy[t]) ft = t;
        g = -1;
        if ((!m_ov || mem_ready) && ft >= 0) begin
            for (int k = 0; k < 3; k++) begin
                cand = (m_ptr + k) % 3;
                if (g < 0 && rv[cand] && !(rq[cand].we && m_stores == 7)) g = cand;
            end
        end
        e_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
        e_rsp = 3'b000;
        if (rsp_v && m_busy[rsp_tid]) e_rsp = 3'(1 << m_owner[rsp_tid]);
        @(posedge clk);
        if (rsp_v && m_busy[rsp_tid]) begin
            m_busy[rsp_tid] = 0;
            if (m_st[rsp_tid]) m_stores--;
        end
        if (g >= 0) begin
            m_busy[ft] = 1; m_owner[ft] = g; m_st[ft] = rq[g].we;
            if (rq[g].we) m_stores++;
            m_ptr = (g + 1) % 3;
            m_ov = 1; m_otid = ft; m_oreq = rq[g];
        end else if (mem_ready) begin
            m_ov = 0;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        nrun++; if (mem_valid !== 1'b0) begin nfail++; $display("FAIL reset_mem_valid got %b exp 0", mem_valid); end
        nrun++; if (busy !== 1'b0) begin nfail++; $display("FAIL reset_busy got %b exp 0", busy); end
        nrun++; if (req_ready !== 3'b000) begin nfail++; $display("FAIL reset_ready got %b exp 000", req_ready); end
        nrun++; if (mtid !== 3'd0 || mreq !== '0) begin nfail++; $display("FAIL reset_payload tid %0d exp 0", mtid); end
        nrun++; if (rsp_valid !== 3'b000) begin nfail++; $display("FAIL reset_rsp got %b exp 000", rsp_valid); end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int c = 0; c < 12; c++) begin
            rv = 3'b111;
            for (int i = 0; i < 3; i++) set_req(i, 0);
            rsp_v = m_ov; rsp_tid = 3'(m_otid);
            tick();
            nrun++; if (s_ready !== e_ready || s_ready !== 3'(1 << (c % 3))) begin
                nfail++; $display("FAIL rr_grant cyc %0d got %b exp %b", c, s_ready, e_ready); end
            nrun++; if (s_rsp !== e_rsp) begin
                nfail++; $display("FAIL rr_rsp cyc %0d got %b exp %b", c, s_rsp, e_rsp); end
            nrun++; if (mem_valid !== 1'b1 || mtid !== 3'(m_otid) || mreq !== m_oreq) begin
                nfail++; $display("FAIL rr_out cyc %0d tid %0d exp %0d", c, mtid, m_otid); end
        end
        idle();
    endtask

    task automatic test_store_limit();
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            rv = 3'b100; set_req(2, 1);
            tick();
            nrun++; if (s_ready !== 3'b100 || mtid !== 3'(c)) begin
                nfail++; $display("FAIL st_issue %0d ready %b tid %0d exp 100 %0d", c, s_ready, mtid, c); end
        end
        rv = 3'b100; set_req(2, 1);
        tick();
        nrun++; if (s_ready !== 3'b000) begin nfail++; $display("FAIL st_8th_blocked got %b exp 000", s_ready); end
        rv = 3'b101; set_req(0, 0); set_req(2, 1);
        tick();
        nrun++; if (s_ready !== 3'b001 || mtid !== 3'd7) begin
            nfail++; $display("FAIL st_load_pass ready %b tid %0d exp 001 7", s_ready, mtid); end
        idle();
    endtask

    task automatic test_pool_exhaust();
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            rv = 3'b010; set_req(1, 0);
            tick();
            nrun++; if (s_ready !== 3'b010 || mtid !== 3'(c)) begin
                nfail++; $display("FAIL pool_issue %0d ready %b tid %0d", c, s_ready, mtid); end
        end
        rv = 3'b011; set_req(0, 0); set_req(1, 0);
        tick();
        nrun++; if (s_ready !== 3'b000 || busy !== 1'b1) begin
            nfail++; $display("FAIL pool_empty ready %b busy %b exp 000 1", s_ready, busy); end
        rsp_v = 1'b1; rsp_tid = 3'd3; rsp_data = {$urandom, $urandom};
        tick();
        nrun++; if (s_rsp !== 3'b010 || s_data !== rsp_data || s_ready !== 3'b000) begin
            nfail++; $display("FAIL pool_rsp rsp %b ready %b exp 010 000", s_rsp, s_ready); end
        rsp_v = 1'b0;
        tick();
        nrun++; if (s_ready !== e_ready || s_ready === 3'b000 || mtid !== 3'd3) begin
            nfail++; $display("FAIL pool_reuse ready %b tid %0d exp %b 3", s_ready, mtid, e_ready); end
        idle();
    endtask

    task automatic test_backpressure();
        mem_req_t held;
        apply_reset();
        rv = 3'b001; set_req(0, 0);
        held = rq[0];
        tick();
        for (int c = 0; c < 5; c++) begin
            mem_ready = 1'b0; rv = 3'b111;
            for (int i = 0; i < 3; i++) set_req(i, 0);
            tick();
            nrun++; if (s_ready !== 3'b000 || mem_valid !== 1'b1 || mreq !== held || mtid !== 3'd0) begin
                nfail++; $display("FAIL bp_hold %0d ready %b valid %b tid %0d", c, s_ready, mem_valid, mtid); end
        end
        mem_ready = 1'b1;
        tick();
        nrun++; if (s_ready !== 3'b010 || mtid !== 3'd1) begin
            nfail++; $display("FAIL bp_release ready %b tid %0d exp 010 1", s_ready, mtid); end
        idle();
    endtask

    task automatic test_store_ack();
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            rv = 3'b100; set_req(2, 1);
            tick();
        end
        rv = 3'b000; rsp_v = 1'b1; rsp_tid = 3'd7;
        tick();
        nrun++; if (s_rsp !== 3'b000) begin nfail++; $display("FAIL free_tid_rsp got %b exp 000", s_rsp); end
        rv = 3'b100; set_req(2, 1); rsp_v = 1'b1; rsp_tid = 3'd0;
        tick();
        nrun++; if (s_ready !== 3'b000 || s_rsp !== 3'b100) begin
            nfail++; $display("FAIL sa_full ready %b rsp %b exp 000 100", s_ready, s_rsp); end
        set_req(2, 1); rsp_tid = 3'd1;
        tick();
        nrun++; if (s_ready !== 3'b100 || mtid !== 3'd0) begin
            nfail++; $display("FAIL sa_same_cycle ready %b tid %0d exp 100 0", s_ready, mtid); end
        rsp_v = 1'b0; set_req(2, 1);
        tick();
        nrun++; if (s_ready !== 3'b100 || mtid !== 3'd1) begin
            nfail++; $display("FAIL sa_refill ready %b tid %0d exp 100 1", s_ready, mtid); end
        set_req(2, 1);
        tick();
        nrun++; if (s_ready !== 3'b000) begin nfail++; $display("FAIL sa_limit got %b exp 000", s_ready); end
        idle();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            rv = 3'b011; set_req(0, 0); set_req(1, 0);
            tick();
        end
        rv = 3'b000;
        #2 rst_n = 1'b0;
        #1;
        nrun++; if (mem_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 3'b000 || mtid !== 3'd0) begin
            nfail++; $display("FAIL mid_reset valid %b busy %b tid %0d", mem_valid, busy, mtid); end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        @(negedge clk);
        rv = 3'b010; set_req(1, 0);
        tick();
        nrun++; if (s_ready !== 3'b010 || mtid !== 3'd0) begin
            nfail++; $display("FAIL post_reset ready %b tid %0d exp 010 0", s_ready, mtid); end
        idle();
    endtask

    task automatic test_random();
        int q[$];
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            rv = 3'($urandom);
            for (int i = 0; i < 3; i++) set_req(i, 1'($urandom));
            mem_ready = ($urandom_range(0, 3) != 0);
            q.delete();
            for (int t = 0; t < 8; t++) if (m_busy[t]) q.push_back(t);
            rsp_v = 1'b0; rsp_tid = '0; rsp_data = {$urandom, $urandom};
            if (q.size() > 0 && $urandom_range(0, 2) != 0) begin
                rsp_v = 1'b1; rsp_tid = 3'(q[$urandom_range(0, q.size() - 1)]);
            end
            tick();
            nrun++; if (s_ready !== e_ready || s_rsp !== e_rsp) begin
                nfail++; $display("FAIL rnd_comb %0d ready %b/%b rsp %b/%b", c, s_ready, e_ready, s_rsp, e_rsp); end
            nrun++; if (e_rsp != 0 && s_data !== rsp_data) begin
                nfail++; $display("FAIL rnd_data %0d got %h exp %h", c, s_data, rsp_data); end
            nrun++; if (mem_valid !== m_ov || (m_ov && (mtid !== 3'(m_otid) || mreq !== m_oreq))) begin
                nfail++; $display("FAIL rnd_out %0d valid %b/%b tid %0d/%0d", c, mem_valid, m_ov, mtid, m_otid); end
            nrun++; if (busy !== (m_ov | model_any_busy())) begin
                nfail++; $display("FAIL rnd_busy %0d got %b", c, busy); end
        end
        idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        model_reset();
        test_reset();
        test_round_robin();
        test_store_limit();
        test_pool_exhaust();
        test_backpressure();
        test_store_ack();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

endmodule
